crc_check_arbiter: RTL and testbench

CRC_CHECK_ARBITER -- requirements
Module: crc_check_arbiter

---
 rtl/crc_check_arbiter_pkg.sv | 23 ++
 rtl/crc_check_arbiter_engine.sv | 55 +++++
 rtl/crc_check_arbiter.sv | 119 +++++++++++
 tb/tb_crc_check_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/crc_check_arbiter_pkg.sv
// Shared definitions for the CRC-8 check arbiter.
//   state_t / ST_*  : FSM state encoding
//   CRC8_POLY       : default generator (x^8+x^6+x^4+x^2+1, x^8 implicit)
//   frame_len()     : serial frame length = payload + CRC bits
package crc_check_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

    localparam logic [7:0] CRC8_POLY = 8'h55;
    localparam int CRC_W = 8;
    localparam int DEF_FRAME_W = 64 + CRC_W;

    function automatic int frame_len(input int data_w);
        return data_w + CRC_W;
    endfunction

endpackage

// File: rtl/crc_check_arbiter_engine.sv
// Serial CRC-8 engine: shifts a {payload, crc} frame MSB-first through an
// 8-bit remainder register, one bit per clock.
//   i_start : load i_frame, clear remainder and bit counter
//   o_done  : high during the cycle that performs the last shift
//   o_rem   : running remainder (final value valid the cycle after o_done)
module crc8_serial_engine
    import crc_check_arbiter_pkg::*;
#(
    parameter int         FRAME_W = DEF_FRAME_W,
    parameter logic [7:0] POLY    = CRC8_POLY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame,
    output logic               o_done,
    output logic [7:0]         o_rem
);

    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] r_sreg;
    logic [7:0]         r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic               w_bit;
    logic [7:0]         w_rem_nxt;

    assign w_bit     = r_sreg[FRAME_W-1];
    // Bit shifted out of rem[7] decides whether the generator is subtracted.
    assign w_rem_nxt = {r_rem[6:0], w_bit} ^ (r_rem[7] ? POLY : 8'h00);
    // Combinational so the FSM leaves SHIFT on the same edge as the last shift.
    assign o_done    = r_active && (r_cnt == CNT_W'(FRAME_W - 1));
    assign o_rem     = r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_sreg   <= i_frame;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (o_done) r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/crc_check_arbiter.sv
// Round-robin arbiter sharing one serial CRC-8 checker among NREQ requesters.
//   req/data_in/crc_in : per-requester level request, payload, received CRC
//   busy               : FSM not in IDLE
//   gnt                : one-hot grant, held from grant through RESP
//   ack/pass           : one-cycle completion pulse and its result
//   crc_out            : last final remainder
//   err_cnt            : saturating count of failed checks
module crc_check_arbiter
    import crc_check_arbiter_pkg::*;
#(
    parameter int         NREQ   = 4,
    parameter int         DATA_W = 64,
    parameter logic [7:0] POLY   = CRC8_POLY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data_in,
    input  logic [NREQ*CRC_W-1:0]  crc_in,
    output logic                   busy,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic                   pass,
    output logic [7:0]             crc_out,
    output logic [15:0]            err_cnt
);

    localparam int FRAME_W = frame_len(DATA_W);
    localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [NREQ-1:0]    r_gnt;
    logic               r_pass;
    logic [7:0]         r_crc_out;
    logic [15:0]        r_err_cnt;

    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [FRAME_W-1:0] w_frame;
    logic               w_done;
    logic [7:0]         w_rem;

    // First requester at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        int  w_idx;
        logic w_found;
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_frame   = {data_in[r_win*DATA_W +: DATA_W], crc_in[r_win*CRC_W +: CRC_W]};

    crc8_serial_engine #(
        .FRAME_W (FRAME_W),
        .POLY    (POLY)
    ) u_engine (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (r_state == ST_LOAD),
        .i_frame (w_frame),
        .o_done  (w_done),
        .o_rem   (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_gnt     <= '0;
            r_pass    <= 1'b0;
            r_crc_out <= '0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (|req) begin
                    r_win   <= w_win;
                    r_gnt   <= NREQ'(1) << w_win;
                    r_ptr   <= w_ptr_nxt;
                    r_state <= ST_LOAD;
                end
                ST_LOAD:  r_state <= ST_SHIFT;
                ST_SHIFT: if (w_done) r_state <= ST_CHECK;
                ST_CHECK: begin
                    r_crc_out <= w_rem;
                    r_pass    <= (w_rem == 8'h00);
                    if (w_rem != 8'h00 && r_err_cnt != 16'hFFFF)
                        r_err_cnt <= r_err_cnt + 16'd1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // Always return through IDLE: no back-to-back grant.
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign gnt     = r_gnt;
    assign ack     = (r_state == ST_RESP) ? r_gnt : '0;
    assign pass    = (r_state == ST_RESP) & r_pass;
    assign crc_out = r_crc_out;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_crc_check_arbiter.sv
module tb_crc_check_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [255:0] data_in;
    logic [31:0]  crc_in;
    logic         busy;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic         pass;
    logic [7:0]   crc_out;
    logic [15:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crc_check_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .crc_in  (crc_in),
        .busy    (busy),
        .gnt     (gnt),
        .ack     (ack),
        .pass    (pass),
        .crc_out (crc_out),
        .err_cnt (err_cnt)
    );

    task set_slot(input int i, input logic [63:0] d, input logic [7:0] c);
        data_in[i*64 +: 64] = d;
        crc_in[i*8 +: 8]    = c;
    endtask

    // Raise req, count edges (grant edge = 1) until ack is seen, drop req.
    task do_op(input logic [3:0] r, output int n, output logic [3:0] a, output logic p);
        req = r; n = 0; a = 4'b0; p = 1'b0;
        while (n < 200) begin
            @(posedge clk); n++; #1;
            if (ack !== 4'b0) begin a = ack; p = pass; break; end
        end
        req = 4'b0;
    endtask

    task test_reset;
        rst_n = 1'b0; req = 4'b0; data_in = '0; crc_in = '0;
        #12;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (gnt !== 4'b0)      begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        total++; if (ack !== 4'b0)      begin bad++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        total++; if (pass !== 1'b0)     begin bad++; $display("FAIL rst_pass got=%b exp=0", pass); end
        total++; if (crc_out !== 8'h00) begin bad++; $display("FAIL rst_crc got=%h exp=00", crc_out); end
        total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL rst_err got=%h exp=0000", err_cnt); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task test_zero_frame;
        int n; logic [3:0] a; logic p;
        set_slot(0, 64'h0, 8'h00);
        do_op(4'b0001, n, a, p);
        total++; if (n != 75)            begin bad++; $display("FAIL zero_latency got=%0d exp=75", n); end
        total++; if (a !== 4'b0001)      begin bad++; $display("FAIL zero_ack got=%b exp=0001", a); end
        total++; if (p !== 1'b1)         begin bad++; $display("FAIL zero_pass got=%b exp=1", p); end
        total++; if (crc_out !== 8'h00)  begin bad++; $display("FAIL zero_crc got=%h exp=00", crc_out); end
        total++; if (err_cnt !== 16'd0)  begin bad++; $display("FAIL zero_err got=%0d exp=0", err_cnt); end
        @(posedge clk); #1;
        total++; if (ack !== 4'b0 || pass !== 1'b0)
            begin bad++; $display("FAIL zero_post_ack got ack=%b pass=%b exp 0000/0", ack, pass); end
    endtask

    task test_crc_err;
        int n; logic [3:0] a; logic p;
        // x^8 mod P = P, so payload 1 with crc 00 leaves 0x55; crc 0x55 cancels it.
        set_slot(1, 64'h1, 8'h00);
        do_op(4'b0010, n, a, p);
        total++; if (a !== 4'b0010)      begin bad++; $display("FAIL err_ack got=%b exp=0010", a); end
        total++; if (p !== 1'b0)         begin bad++; $display("FAIL err_pass got=%b exp=0", p); end
        total++; if (crc_out !== 8'h55)  begin bad++; $display("FAIL err_crc got=%h exp=55", crc_out); end
        total++; if (err_cnt !== 16'd1)  begin bad++; $display("FAIL err_cnt1 got=%0d exp=1", err_cnt); end
        set_slot(1, 64'h1, 8'h55);
        do_op(4'b0010, n, a, p);
        total++; if (p !== 1'b1)         begin bad++; $display("FAIL good_pass got=%b exp=1", p); end
        total++; if (crc_out !== 8'h00)  begin bad++; $display("FAIL good_crc got=%h exp=00", crc_out); end
        total++; if (err_cnt !== 16'd1)  begin bad++; $display("FAIL good_err got=%0d exp=1", err_cnt); end
    endtask

    task test_round_robin;
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        logic [3:0] eg;
        int w; int n;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_slot(i, 64'h0, 8'h00);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            eg = 4'b0001 << exp_ord[j];
            w = 0;
            while (gnt === 4'b0 && w < 10) begin @(posedge clk); w++; #1; end
            total++; if (w != 1)    begin bad++; $display("FAIL rr_gap%0d got=%0d exp=1", j, w); end
            total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", j, gnt, eg); end
            n = 0;
            while (ack === 4'b0 && n < 100) begin @(posedge clk); n++; #1; end
            total++; if (ack !== eg) begin bad++; $display("FAIL rr_ack%0d got=%b exp=%b", j, ack, eg); end
            @(posedge clk); #1;
            total++; if (busy !== 1'b0 || gnt !== 4'b0)
                begin bad++; $display("FAIL rr_idle%0d got busy=%b gnt=%b exp 0/0000", j, busy, gnt); end
        end
        req = 4'b0;
    endtask

    task test_ignore_inputs;
        int n; logic [3:0] a; logic p;
        set_slot(2, 64'h1, 8'h55);
        req = 4'b0100;
        @(posedge clk); @(posedge clk); #1;
        // Corrupt inputs and drop the request once LOAD has captured them.
        set_slot(2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        req = 4'b0;
        n = 0; a = 4'b0; p = 1'b0;
        while (n < 200) begin
            @(posedge clk); n++; #1;
            if (ack !== 4'b0) begin a = ack; p = pass; break; end
        end
        total++; if (n != 73)           begin bad++; $display("FAIL ign_latency got=%0d exp=73", n); end
        total++; if (a !== 4'b0100)     begin bad++; $display("FAIL ign_ack got=%b exp=0100", a); end
        total++; if (p !== 1'b1)        begin bad++; $display("FAIL ign_pass got=%b exp=1", p); end
        total++; if (crc_out !== 8'h00) begin bad++; $display("FAIL ign_crc got=%h exp=00", crc_out); end
    endtask

    task test_reset_mid;
        int n; logic [3:0] a; logic p; logic seen;
        set_slot(2, 64'h1, 8'h00);
        req = 4'b0100;
        @(posedge clk); @(posedge clk);
        repeat (30) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (gnt !== 4'b0)      begin bad++; $display("FAIL mid_gnt got=%b exp=0000", gnt); end
        total++; if (ack !== 4'b0 || pass !== 1'b0)
            begin bad++; $display("FAIL mid_ack got ack=%b pass=%b exp 0000/0", ack, pass); end
        total++; if (crc_out !== 8'h00 || err_cnt !== 16'd0)
            begin bad++; $display("FAIL mid_regs got crc=%h err=%h exp 00/0000", crc_out, err_cnt); end
        req = 4'b0;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (100) begin @(posedge clk); #1; if (ack !== 4'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0)     begin bad++; $display("FAIL mid_no_ack got=%b exp=0", seen); end
        // With ptr back at 0, requester 1 wins over 3.
        set_slot(1, 64'h0, 8'h00); set_slot(3, 64'h0, 8'h00);
        do_op(4'b1010, n, a, p);
        total++; if (a !== 4'b0010)     begin bad++; $display("FAIL mid_next_ack got=%b exp=0010", a); end
        total++; if (n != 75 || p !== 1'b1)
            begin bad++; $display("FAIL mid_next got n=%0d pass=%b exp 75/1", n, p); end
    endtask

    task test_saturate;
        int n; logic [3:0] a; logic p;
        force dut.r_err_cnt = 16'hFFFE;
        @(posedge clk); #1;
        release dut.r_err_cnt;
        #1;
        total++; if (err_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", err_cnt); end
        set_slot(0, 64'h1, 8'h00);
        do_op(4'b0001, n, a, p);
        total++; if (err_cnt !== 16'hFFFF || p !== 1'b0)
            begin bad++; $display("FAIL sat_first got err=%h pass=%b exp ffff/0", err_cnt, p); end
        do_op(4'b0001, n, a, p);
        total++; if (err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", err_cnt); end
        total++; if (a !== 4'b0001)        begin bad++; $display("FAIL sat_ack got=%b exp=0001", a); end
    endtask

    initial begin
        test_reset;
        test_zero_frame;
        test_crc_err;
        test_round_robin;
        test_ignore_inputs;
        test_reset_mid;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
